counter_run_controller: RTL
===========================

Name: counter_run_controller

Overview:
- Run/pause/stop sequencer for the hex up/down counter that drives the seven-segment decoder.
- Replaces the free-running divided clock with a single-cycle tick enable in the system clock domain.
- Owns the count register, the direction, and the wrap or bounce policy.
- The count output feeds the seven-segment decoder directly; no derived clocks.

Parameters:
TICK_DIV, 50000000, clock cycles per count step; legal range >= 2
WIDTH, 4, count width in bits
MAX_VAL, 15, upper count bound; must be <= 2^WIDTH-1; lower bound fixed at 0

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_start  in  1  raw start button, active-high, asynchronous to clock
btn_stop  in  1  raw stop button, active-high, asynchronous to clock
btn_dir  in  1  raw direction-toggle button, active-high, asynchronous to clock
mode_bounce  in  1  0 = wrap at bounds, 1 = reverse at bounds; level, sampled every cycle
count  out  WIDTH  current count value, to the seven-segment decoder
up_down  out  1  current direction; 1 = up, 0 = down
tick  out  1  single-cycle pulse on each count step
running  out  1  high while in RUN
at_limit  out  1  combinational: (up_down && count==MAX_VAL) || (!up_down && count==0)

Behaviour:
- Reset (reset=0, async) values:
  - state = IDLE
  - count = 0, up_down = 1, tick = 0, running = 0
  - prescaler = 0, all sync and edge-detect flops = 0
- Button conditioning, per button:
  - 2-flop synchronizer, then rising-edge detect.
  - Produces one internal press pulse per button per press.
  - Press pulse is valid 3 clock edges after the raw input is first sampled high.
  - Held buttons produce no repeat pulses. No debounce inside this block.
- FSM, states IDLE, RUN, PAUSE:
  - IDLE, start press -> RUN.
  - RUN, stop press -> PAUSE.
  - PAUSE, start press -> RUN.
  - PAUSE, stop press -> IDLE; on entry, count = 0 and up_down = 1.
  - Start and stop pressed in the same cycle: stop wins.
  - Start press in RUN and stop press in IDLE are ignored.
- Prescaler, 0..TICK_DIV-1:
  - RUN: increments every cycle.
  - PAUSE: holds its value, so resume continues the partial period.
  - IDLE: cleared to 0.
  - RUN with prescaler == TICK_DIV-1, on that edge: prescaler <= 0, tick <= 1, count <= next value. tick is otherwise 0.
  - First tick after IDLE->RUN is TICK_DIV cycles after the RUN entry edge.
  - Stop press on a terminal-count cycle: the step still occurs; the state still goes to PAUSE.
- Step rules, wrap mode (mode_bounce=0):
  - Up: MAX_VAL -> 0, otherwise +1.
  - Down: 0 -> MAX_VAL, otherwise -1.
- Step rules, bounce mode (mode_bounce=1):
  - Up at MAX_VAL: count <= MAX_VAL-1 and direction reverses to down.
  - Down at 0: count <= 1 and direction reverses to up.
- Direction press:
  - Toggles up_down in RUN and PAUSE; ignored in IDLE.
  - On a step edge, the step uses the pre-edge up_down.
  - New up_down = (bounce-reversed value) XOR (dir press).
- mode_bounce changes take effect at the next step. A count already outside 0..MAX_VAL cannot occur.
- Reset asserted mid-operation: immediate return to reset values. A pending press pulse is lost.
- All outputs are registered except at_limit.

Test Plan:
- TICK_DIV=4, reset, then one start press -> running=1 three edges later; tick every 4 cycles; count 0,1,2,...,15,0 (wrap); up_down stays 1.
- RUN up at count=3, stop press -> PAUSE, count holds 3, prescaler frozen; start press -> next tick arrives after the remaining partial period; count becomes 4.
- mode_bounce=1, run up from 0 -> count ...,14,15,14,13; up_down falls on the 15->14 step; at_limit=1 while count=15 with up_down=1; later 1,0,1 with up_down rising.
- Wrap mode, count=0 in RUN, dir press -> up_down=0; next tick gives count=15. Dir press coincident with a tick -> step uses the old direction, then up_down toggles.
- Start and stop pressed the same cycle in IDLE -> stays IDLE. Stop in RUN, stop again -> IDLE with count=0, up_down=1. Held start button -> exactly one press.
- Assert reset mid-RUN with count=9, prescaler=2 -> all outputs return to reset values asynchronously; after release, the counter stays in IDLE until a start press.

Source files
------------

// File: rtl/counter_run_if.sv
// counter_run_if
//   Bundles the button/mode inputs and the counter outputs of the
//   counter run controller.
//   master : drives btn_start, btn_stop, btn_dir, mode_bounce;
//            observes count, up_down, tick, running, at_limit
//   slave  : the controller itself (mirror of master)
interface counter_run_if #(
    parameter int WIDTH = 4
) ();
    logic             btn_start;
    logic             btn_stop;
    logic             btn_dir;
    logic             mode_bounce;
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             tick;
    logic             running;
    logic             at_limit;

    modport master (
        output btn_start, btn_stop, btn_dir, mode_bounce,
        input  count, up_down, tick, running, at_limit
    );

    modport slave (
        input  btn_start, btn_stop, btn_dir, mode_bounce,
        output count, up_down, tick, running, at_limit
    );
endinterface

// File: rtl/counter_run_controller.sv
// counter_run_controller
//   Run/pause/stop sequencer for the hex up/down counter feeding the
//   seven-segment decoder. A prescaler in the clock domain produces a
//   single-cycle tick per count step; no derived clocks.
//   Ports:
//     clock  : system clock
//     reset  : asynchronous, active-low reset
//     bus    : counter_run_if.slave
//              in : btn_start, btn_stop, btn_dir (raw, async), mode_bounce
//              out: count, up_down, tick, running (registered),
//                   at_limit (combinational)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, count 0 / direction up, prescaler held at 0
//   RUN   | prescaler advancing, count steps at each terminal count
//   PAUSE | frozen; prescaler keeps its partial period for resume
module counter_run_controller #(
    parameter int TICK_DIV = 50000000,
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15
) (
    input logic           clock,
    input logic           reset,
    counter_run_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] count_q;
    logic             up_down_q;
    logic             tick_q;
    logic             running_q;

    // [0],[1] form the synchronizer; [2] is the edge-detect history.
    logic [2:0] start_sync;
    logic [2:0] stop_sync;
    logic [2:0] dir_sync;

    logic start_press;
    logic stop_press;
    logic dir_press;

    logic [WIDTH-1:0] step_count;
    logic             step_dir;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_sync <= '0;
            stop_sync  <= '0;
            dir_sync   <= '0;
        end else begin
            start_sync <= {start_sync[1:0], bus.btn_start};
            stop_sync  <= {stop_sync[1:0],  bus.btn_stop};
            dir_sync   <= {dir_sync[1:0],   bus.btn_dir};
        end
    end

    assign start_press = start_sync[1] & ~start_sync[2];
    assign stop_press  = stop_sync[1]  & ~stop_sync[2];
    assign dir_press   = dir_sync[1]   & ~dir_sync[2];

    // Next count/direction for a step, taken from the pre-edge direction.
    // Bounce mode reflects off the bounds instead of wrapping.
    always_comb begin
        step_count = count_q;
        step_dir   = up_down_q;
        if (up_down_q) begin
            if (count_q == MAX_C) begin
                if (bus.mode_bounce) begin
                    step_count = MAX_C - ONE_C;
                    step_dir   = 1'b0;
                end else begin
                    step_count = '0;
                end
            end else begin
                step_count = count_q + ONE_C;
            end
        end else begin
            if (count_q == '0) begin
                if (bus.mode_bounce) begin
                    step_count = ONE_C;
                    step_dir   = 1'b1;
                end else begin
                    step_count = MAX_C;
                end
            end else begin
                step_count = count_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            count_q   <= '0;
            up_down_q <= 1'b1;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                IDLE: begin
                    presc <= '0;
                    // stop wins over a simultaneous start
                    if (start_press && !stop_press) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (presc == PRESC_LAST) begin
                        presc     <= '0;
                        tick_q    <= 1'b1;
                        count_q   <= step_count;
                        up_down_q <= step_dir ^ dir_press;
                    end else begin
                        presc     <= presc + PRESC_ONE;
                        up_down_q <= up_down_q ^ dir_press;
                    end
                    // a stop on the terminal cycle still lets the step land
                    if (stop_press) begin
                        state     <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    up_down_q <= up_down_q ^ dir_press;
                    if (stop_press) begin
                        state     <= IDLE;
                        count_q   <= '0;
                        up_down_q <= 1'b1;
                    end else if (start_press) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.up_down  = up_down_q;
    assign bus.tick     = tick_q;
    assign bus.running  = running_q;
    assign bus.at_limit = (up_down_q && (count_q == MAX_C)) ||
                          (!up_down_q && (count_q == '0));
endmodule
